// File: rtl/ct_f_spsram_256x7_acc_ctrl_pkg.sv
// Shared types and constants for the 256x7 single-port SRAM access controller.
package ct_f_spsram_256x7_acc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT_PEND = 2'd0,
        ST_INIT      = 2'd1,
        ST_RUN       = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 7;
    localparam int RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/ct_f_spsram_256x7.sv
// Behavioural 256x7 single-port SRAM: active-low CEN/GWEN/WEN, registered Q.
module ct_f_spsram_256x7 (
    input  logic       clk,
    input  logic [7:0] a,
    input  logic       cen,
    input  logic       gwen,
    input  logic [6:0] wen,
    input  logic [6:0] d,
    output logic [6:0] q
);

    logic [6:0] mem [256];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!gwen) begin
                mem[a] <= (mem[a] & wen) | (d & ~wen);
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/ct_f_spsram_256x7_acc_ctrl_rsp_fifo.sv
// Two-entry read response buffer; push and pop may coincide.
module ct_f_spsram_rsp_fifo
    import ct_f_spsram_256x7_acc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];
    logic                  wptr;
    logic                  rptr;
    logic                  do_pop;

    assign vld    = (cnt != 2'd0);
    assign rdata  = mem[rptr];
    assign do_pop = pop & vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ct_f_spsram_256x7_acc_ctrl.sv
// Initiator-side SRAM access controller: request stream to SRAM cycles,
// response buffering, and a full-array clear sweep after reset or on demand.
module ct_f_spsram_256x7_acc_ctrl
    import ct_f_spsram_256x7_acc_ctrl_pkg::*;
#(
    parameter int                   ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_start,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  rd_inflight;
    logic [1:0]            fifo_cnt;
    logic                  rsp_pop;
    logic [2:0]            occ;
    logic                  accept;

    assign rsp_pop   = rsp_vld & rsp_rdy;
    assign occ       = {1'b0, fifo_cnt} + {2'b0, rd_inflight};
    // A pop this cycle frees a slot for a read accepted in the same cycle.
    assign req_rdy   = (state == ST_RUN) && (occ < (3'd2 + {2'b0, rsp_pop}));
    assign accept    = req_vld & req_rdy;
    assign init_done = (state == ST_RUN);

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        if (state == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt;
            sram_d    = INIT_VAL;
        end else if (accept) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_wmask;
                sram_d    = req_wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state       <= ST_INIT_PEND;
            cnt         <= '0;
            a_q         <= '0;
            d_q         <= '0;
            rd_inflight <= 1'b0;
        end else begin
            a_q         <= sram_a;
            d_q         <= sram_d;
            rd_inflight <= accept & ~req_wr;
            unique case (state)
                ST_INIT_PEND: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
                ST_INIT: begin
                    if (cnt == '1) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_start) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_cnt == 2'd0 && !rd_inflight) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_INIT_PEND;
            endcase
        end
    end

    ct_f_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .push      (rd_inflight),
        .push_data (sram_q),
        .pop       (rsp_pop),
        .vld       (rsp_vld),
        .rdata     (rsp_rdata),
        .cnt       (fifo_cnt)
    );

endmodule

// File: tb/tb_ct_f_spsram_256x7_acc_ctrl.sv
// Directed bench for the SRAM access controller paired with the SRAM model.
module tb_ct_f_spsram_256x7_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init_start;
    logic       init_done;
    logic       req_vld;
    logic       req_rdy;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [6:0] req_wdata;
    logic [6:0] req_wmask;
    logic       rsp_vld;
    logic       rsp_rdy;
    logic [6:0] rsp_rdata;
    logic [7:0] sram_a;
    logic       sram_cen;
    logic       sram_gwen;
    logic [6:0] sram_wen;
    logic [6:0] sram_d;
    logic [6:0] sram_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ct_f_spsram_256x7_acc_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .init_start     (init_start),
        .init_done      (init_done),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    ct_f_spsram_256x7 u_sram (
        .clk  (clk),
        .a    (sram_a),
        .cen  (sram_cen),
        .gwen (sram_gwen),
        .wen  (sram_wen),
        .d    (sram_d),
        .q    (sram_q)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [6:0] wdata;
        logic [6:0] wmask;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (!req_rdy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_rdy) chk({name, "_rdy_timeout"}, 0, 1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [6:0] data,
                            input logic [6:0] mask, input string name);
        @(negedge clk);
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        #1;
        wait_rdy(name);
        chk({name, "_wpins"}, {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
            {1'b0, 1'b0, ~mask, addr, data});
        @(posedge clk);
        #1 req_vld = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [6:0] exp,
                           input string name);
        @(negedge clk);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = addr;
        #1;
        wait_rdy(name);
        chk({name, "_rpins"}, {sram_cen, sram_gwen, sram_wen, sram_a},
            {1'b0, 1'b1, 7'h7f, addr});
        @(posedge clk);
        #1 req_vld = 1'b0;
        @(negedge clk);
        #1 chk({name, "_vld_n1"}, rsp_vld, 0);
        @(negedge clk);
        #1 chk({name, "_data"}, {rsp_vld, rsp_rdata}, {1'b1, exp});
    endtask

    // Entered at the negedge of the first INIT cycle.
    task automatic sweep_check(input string name);
        int errs = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 7'h00 ||
                sram_a !== i[7:0] || sram_d !== 7'h00 || init_done !== 1'b0 ||
                req_rdy !== 1'b0 || rsp_vld !== 1'b0)
                errs++;
            @(posedge clk);
            @(negedge clk);
        end
        chk({name, "_sweep_errs"}, errs, 0);
        #1 chk({name, "_done"}, {init_done, sram_cen, req_rdy}, 3'b111);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [6:0] bexp [8];

        vecs[0] = '{1'b0, 8'hA5, 7'h00, 7'h00, 7'h00, "rd_a5_clear"};
        vecs[1] = '{1'b1, 8'hA5, 7'h55, 7'h7F, 7'h00, "wr_a5"};
        vecs[2] = '{1'b0, 8'hA5, 7'h00, 7'h00, 7'h55, "rd_a5_raw"};
        vecs[3] = '{1'b1, 8'h10, 7'h7F, 7'h7F, 7'h00, "wr_10_full"};
        vecs[4] = '{1'b1, 8'h10, 7'h00, 7'h0F, 7'h00, "wr_10_mask"};
        vecs[5] = '{1'b0, 8'h10, 7'h00, 7'h00, 7'h70, "rd_10"};
        vecs[6] = '{1'b1, 8'h20, 7'h2A, 7'h00, 7'h00, "wr_20_nomask"};
        vecs[7] = '{1'b0, 8'h20, 7'h00, 7'h00, 7'h00, "rd_20"};
        vecs[8] = '{1'b1, 8'h33, 7'h5A, 7'h3C, 7'h00, "wr_33_mask"};

        rst_n      = 1'b0;
        init_start = 1'b0;
        req_vld    = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        rsp_rdy    = 1'b1;

        repeat (2) @(negedge clk);
        #1 chk("reset_outs",
               {req_rdy, rsp_vld, rsp_rdata, init_done, sram_cen, sram_gwen,
                sram_wen, sram_a, sram_d},
               {1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h7f, 8'h00, 7'h00});
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("init_pend_idle", {sram_cen, init_done}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        sweep_check("rst");

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].name);
            else
                do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        do_read(8'h33, 7'h18, "rd_33");

        for (int i = 0; i < 8; i++) begin
            bexp[i] = 7'((i * 9 + 3) & 7'h7f);
            do_write(8'h40 + 8'(i), bexp[i], 7'h7f, "wr_b2b");
        end

        rsp_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_vld  = (c < 8);
            req_wr   = 1'b0;
            req_addr = 8'h40 + 8'(c);
            #1;
            if (c < 8) chk("b2b_rdy", req_rdy, 1);
            chk("b2b_vld", rsp_vld, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) chk("b2b_data", rsp_rdata, bexp[c-2]);
        end
        @(negedge clk);
        req_vld = 1'b0;

        rsp_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_vld  = 1'b1;
            req_wr   = 1'b0;
            req_addr = 8'h40 + 8'(acc < 2 ? acc : 1);
            #1;
            chk("bp_rdy", req_rdy, (c < 2));
            if (req_rdy) acc++;
            if (c >= 3) chk("bp_hold", {rsp_vld, rsp_rdata}, {1'b1, bexp[0]});
        end
        chk("bp_accepted", acc, 2);

        @(negedge clk);
        req_vld    = 1'b0;
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        req_vld    = 1'b1;
        #1 chk("drain_state", {req_rdy, init_done, sram_cen, rsp_vld, rsp_rdata},
               {1'b0, 1'b0, 1'b1, 1'b1, bexp[0]});
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        #1 chk("drain_2nd", {rsp_vld, rsp_rdata}, {1'b1, bexp[1]});
        @(negedge clk);
        #1 chk("drain_empty", {rsp_vld, init_done, req_rdy}, 3'b000);
        @(negedge clk);
        sweep_check("reinit");
        do_read(8'h40, 7'h00, "rd_40_cleared");

        @(negedge clk);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 8'h41;
        #1 chk("rst_rd_rdy", req_rdy, 1);
        @(negedge clk);
        req_vld = 1'b0;
        rst_n   = 1'b0;
        #1 chk("async_rst_outs",
               {req_rdy, rsp_vld, rsp_rdata, init_done, sram_cen, sram_gwen,
                sram_wen, sram_a, sram_d},
               {1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h7f, 8'h00, 7'h00});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("rst_no_rsp", rsp_vld, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        sweep_check("rst2");
        do_read(8'h33, 7'h00, "rd_33_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
